// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the RAM port-0 arbiter and its rotating-priority core.
package ram_arb_pkg;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_NUM_WMASK  = 4;
    localparam int DEF_RD_LATENCY = 1;

    // Record layouts at the default configuration.
    typedef struct packed {
        logic                      we;
        logic [DEF_NUM_WMASK-1:0]  wmask;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] wdata;
    } ram_cmd_t;

    typedef struct packed {
        logic                   valid;
        logic [DEF_NUM_REQ-1:0] id;
    } rsp_tag_t;

    function automatic int wrap_inc(input int i, input int n);
        return (i + 1 >= n) ? 0 : i + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority one-hot arbiter: the search starts at ptr, and ptr moves past each winner.
module rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter  int N  = DEF_NUM_REQ,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx
);

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW:0]   scan_sum;
    logic [PW-1:0] scan_sel;

    // Scan from farthest to nearest so the requester closest to ptr is written last and wins.
    always_comb begin
        gnt      = '0;
        gnt_idx  = '0;
        scan_sum = '0;
        scan_sel = '0;
        if (en) begin
            for (int k = N - 1; k >= 0; k--) begin
                scan_sum = {1'b0, ptr_q} + (PW+1)'(k);
                if (scan_sum >= (PW+1)'(N)) begin
                    scan_sum = scan_sum - (PW+1)'(N);
                end
                scan_sel = scan_sum[PW-1:0];
                if (req[scan_sel]) begin
                    gnt           = '0;
                    gnt[scan_sel] = 1'b1;
                    gnt_idx       = scan_sel;
                end
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (|gnt) begin
            ptr_d = PW'(wrap_inc(int'(gnt_idx), N));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ram_port0_arbiter.sv
// Shares SRAM port 0 between NUM_REQ requesters: registered command issue, and read data
// steered back to its issuer through a tag pipeline aligned with the RAM read latency.
module ram_port0_arbiter
    import ram_arb_pkg::*;
#(
    parameter  int NUM_REQ    = DEF_NUM_REQ,
    parameter  int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int NUM_WMASK  = DEF_NUM_WMASK,
    parameter  int RD_LATENCY = DEF_RD_LATENCY,
    localparam int PW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                            clk0,
    input  logic                            rst_n,
    input  logic                            en,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ-1:0]              req_we,
    input  logic [NUM_REQ*NUM_WMASK-1:0]    req_wmask,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_rdata,
    output logic                            busy,
    output logic                            cs0,
    output logic                            we0,
    output logic [NUM_WMASK-1:0]            wmask0,
    output logic [ADDR_WIDTH-1:0]           addr0,
    output logic [DATA_WIDTH-1:0]           din0,
    input  logic [DATA_WIDTH-1:0]           dout0
);

    logic [NUM_REQ-1:0] gnt;
    logic [PW-1:0]      gnt_idx;
    logic               granted;
    logic               rd_push;

    logic                  cs0_q, cs0_d;
    logic                  we0_q, we0_d;
    logic [NUM_WMASK-1:0]  wmask0_q, wmask0_d;
    logic [ADDR_WIDTH-1:0] addr0_q, addr0_d;
    logic [DATA_WIDTH-1:0] din0_q, din0_d;

    logic [RD_LATENCY:0]              tag_vld_q, tag_vld_d;
    logic [RD_LATENCY:0][NUM_REQ-1:0] tag_id_q, tag_id_d;

    logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr (
        .clk     (clk0),
        .rst_n   (rst_n),
        .en      (en),
        .req     (req_valid),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;
    assign granted   = |gnt;
    assign rd_push   = granted & ~req_we[gnt_idx];

    // Command register: loads only on a grant, so address/data hold while cs0 is low.
    always_comb begin
        cs0_d    = granted;
        we0_d    = we0_q;
        wmask0_d = wmask0_q;
        addr0_d  = addr0_q;
        din0_d   = din0_q;
        if (granted) begin
            we0_d    = req_we[gnt_idx];
            wmask0_d = req_we[gnt_idx] ? req_wmask[gnt_idx*NUM_WMASK +: NUM_WMASK] : '0;
            addr0_d  = req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
            din0_d   = req_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Stage 0 lines up with cs0; the tail lines up with valid dout0.
    always_comb begin
        tag_vld_d    = '0;
        tag_id_d     = '0;
        tag_vld_d[0] = rd_push;
        tag_id_d[0]  = rd_push ? gnt : '0;
        for (int s = 1; s <= RD_LATENCY; s++) begin
            tag_vld_d[s] = tag_vld_q[s-1];
            tag_id_d[s]  = tag_id_q[s-1];
        end
    end

    always_comb begin
        rsp_valid_d = tag_id_q[RD_LATENCY];
        rsp_rdata_d = tag_vld_q[RD_LATENCY] ? dout0 : rsp_rdata_q;
    end

    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            cs0_q       <= 1'b0;
            we0_q       <= 1'b0;
            wmask0_q    <= '0;
            addr0_q     <= '0;
            din0_q      <= '0;
            tag_vld_q   <= '0;
            tag_id_q    <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            cs0_q       <= cs0_d;
            we0_q       <= we0_d;
            wmask0_q    <= wmask0_d;
            addr0_q     <= addr0_d;
            din0_q      <= din0_d;
            tag_vld_q   <= tag_vld_d;
            tag_id_q    <= tag_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign cs0       = cs0_q;
    assign we0       = we0_q;
    assign wmask0    = wmask0_q;
    assign addr0     = addr0_q;
    assign din0      = din0_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign busy      = |tag_vld_q;

endmodule

// File: tb/tb_ram_port0_arbiter.sv
// Self-checking bench for ram_port0_arbiter with a behavioural SRAM on port 0 and a read scoreboard.
module tb_ram_port0_arbiter;

    localparam int NR = 4;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int NW = 4;
    localparam int RL = 1;

    logic                 clk0 = 1'b0;
    logic                 rst_n;
    logic                 en = 1'b0;
    logic [NR-1:0]        req_valid = '0;
    logic [NR-1:0]        req_ready;
    logic [NR-1:0]        req_we = '0;
    logic [NR*NW-1:0]     req_wmask;
    logic [NR*AW-1:0]     req_addr;
    logic [NR*DW-1:0]     req_wdata;
    logic [NR-1:0]        rsp_valid;
    logic [DW-1:0]        rsp_rdata;
    logic                 busy;
    logic                 cs0;
    logic                 we0;
    logic [NW-1:0]        wmask0;
    logic [AW-1:0]        addr0;
    logic [DW-1:0]        din0;
    logic [DW-1:0]        dout0 = '0;

    logic [NW-1:0] t_wmask [NR];
    logic [AW-1:0] t_addr  [NR];
    logic [DW-1:0] t_wdata [NR];

    for (genvar g = 0; g < NR; g++) begin : g_pack
        assign req_wmask[g*NW +: NW] = t_wmask[g];
        assign req_addr[g*AW +: AW]  = t_addr[g];
        assign req_wdata[g*DW +: DW] = t_wdata[g];
    end

    ram_port0_arbiter #(
        .NUM_REQ    (NR),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_WMASK  (NW),
        .RD_LATENCY (RL)
    ) dut (
        .clk0      (clk0),
        .rst_n     (rst_n),
        .en        (en),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_wmask (req_wmask),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .cs0       (cs0),
        .we0       (we0),
        .wmask0    (wmask0),
        .addr0     (addr0),
        .din0      (din0),
        .dout0     (dout0)
    );

    always #5 clk0 = ~clk0;

    // Behavioural SRAM port, one-cycle read latency, byte-lane masked writes.
    logic [DW-1:0] ram_mem [256];
    always @(posedge clk0) begin
        if (cs0) begin
            if (we0) begin
                for (int l = 0; l < NW; l++)
                    if (wmask0[l]) ram_mem[addr0][l*8 +: 8] <= din0[l*8 +: 8];
            end else begin
                dout0 <= ram_mem[addr0];
            end
        end
    end

    typedef struct {
        logic [NR-1:0] id;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    logic [DW-1:0] shadow [256];
    int            model_ptr = 0;
    int            cyc = 0;
    int            n_checks = 0;
    int            n_pass = 0;

    always @(posedge clk0) cyc <= cyc + 1;

    // Scoreboard: every response must match the oldest outstanding read, on its due cycle.
    always @(negedge clk0) begin
        if (rst_n === 1'b1) begin
            if (sb.size() > 0 && sb[0].due < cyc) begin
                n_checks++;
                $display("FAIL rsp_missing: nothing by cycle %0d, required id %b at cycle %0d",
                         cyc, sb[0].id, sb[0].due);
                void'(sb.pop_front());
            end
            if (rsp_valid !== '0) begin
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL rsp_unexpected: got id %b data %h, required no response",
                             rsp_valid, rsp_rdata);
                end else begin
                    mon_e = sb.pop_front();
                    if (rsp_valid !== mon_e.id || rsp_rdata !== mon_e.data || cyc != mon_e.due)
                        $display("FAIL rsp_match: got id %b data %h cycle %0d, required id %b data %h cycle %0d",
                                 rsp_valid, rsp_rdata, cyc, mon_e.id, mon_e.data, mon_e.due);
                    else
                        n_pass++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk0);
        @(negedge clk0);
    endtask

    // Reference arbitration for the inputs currently driven; records writes and expected reads.
    task automatic arb_step(output logic [NR-1:0] exp_gnt);
        exp_gnt = '0;
        if (en) begin
            for (int k = 0; k < NR; k++) begin
                int i = (model_ptr + k) % NR;
                if (req_valid[i]) begin
                    exp_gnt[i] = 1'b1;
                    model_ptr  = (i + 1) % NR;
                    if (req_we[i]) begin
                        for (int l = 0; l < NW; l++)
                            if (t_wmask[i][l]) shadow[t_addr[i]][l*8 +: 8] = t_wdata[i][l*8 +: 8];
                    end else begin
                        sb.push_back('{id: exp_gnt, data: shadow[t_addr[i]], due: cyc + 2 + RL});
                    end
                    break;
                end
            end
        end
    endtask

    task automatic set_req(input int i, input logic we, input logic [NW-1:0] m,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_we[i]  = we;
        t_wmask[i] = m;
        t_addr[i]  = a;
        t_wdata[i] = d;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
        n_checks++;
        if (sb.size() != 0) $display("FAIL drain: %0d reads outstanding, required 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        logic [NR-1:0] g;
        int            seen;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({cs0, we0, wmask0, addr0, din0, rsp_valid, rsp_rdata, busy, req_ready} !== '0)
            $display("FAIL reset_outputs: cs0=%b we0=%b wmask0=%h addr0=%h din0=%h rsp_valid=%b busy=%b, required all 0",
                     cs0, we0, wmask0, addr0, din0, rsp_valid, busy);
        else n_pass++;
        repeat (2) @(negedge clk0);
        rst_n = 1'b1;
        en    = 1'b1;
        set_req(0, 1'b0, 4'hF, 8'h05, '0);
        req_valid = 4'b0001;
        arb_step(g);
        #1;
        n_checks++;
        if (req_ready !== g) $display("FAIL reset_first_grant: got %b required %b", req_ready, g);
        else n_pass++;
        tick();
        req_valid = '0;
        n_checks++;
        if (cs0 !== 1'b1 || busy !== 1'b1) $display("FAIL reset_inflight: cs0=%b busy=%b required 1 1", cs0, busy);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({cs0, we0, wmask0, addr0, din0, rsp_valid, rsp_rdata, busy, req_ready} !== '0)
            $display("FAIL reset_midread: cs0=%b busy=%b addr0=%h rsp_valid=%b, required all 0",
                     cs0, busy, addr0, rsp_valid);
        else n_pass++;
        sb.delete();
        model_ptr = 0;
        tick();
        rst_n = 1'b1;
        seen = 0;
        repeat (5) begin
            tick();
            if (rsp_valid !== '0) seen++;
        end
        n_checks++;
        if (seen != 0) $display("FAIL reset_dropped_read: got %0d responses required 0", seen);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] g;
        logic [NR-1:0] want;
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, 4'hF, AW'(8'h40 + i), '0);
        req_valid = '1;
        for (int c = 0; c < 8; c++) begin
            arb_step(g);
            want = NR'(1) << (c % NR);
            #1;
            n_checks++;
            if (req_ready !== want) $display("FAIL rr_grant%0d: got %b required %b", c, req_ready, want);
            else n_pass++;
            tick();
            n_checks++;
            if (cs0 !== 1'b1 || addr0 !== AW'(8'h40 + (c % NR)))
                $display("FAIL rr_cs0_%0d: cs0=%b addr0=%h required 1 %h", c, cs0, addr0, 8'h40 + (c % NR));
            else n_pass++;
        end
        req_valid = '0;
        tick();
        n_checks++;
        if (cs0 !== 1'b0) $display("FAIL rr_cs0_idle: got %b required 0", cs0);
        else n_pass++;
        drain();
    endtask

    task automatic test_write_read();
        logic [NR-1:0] g;
        set_req(2, 1'b1, 4'hF, 8'h10, 32'hDEADBEEF);
        set_req(1, 1'b0, 4'hF, 8'h10, 32'h0BAD0BAD);
        req_valid = 4'b0100;
        arb_step(g);
        tick();
        n_checks++;
        if ({cs0, we0, wmask0, addr0, din0} !== {1'b1, 1'b1, 4'hF, 8'h10, 32'hDEADBEEF})
            $display("FAIL wr_cmd: cs0=%b we0=%b wmask0=%h addr0=%h din0=%h required 1 1 f 10 deadbeef",
                     cs0, we0, wmask0, addr0, din0);
        else n_pass++;
        req_valid = 4'b0010;
        arb_step(g);
        tick();
        req_valid = '0;
        n_checks++;
        if ({cs0, we0, wmask0, addr0} !== {1'b1, 1'b0, 4'h0, 8'h10})
            $display("FAIL rd_cmd: cs0=%b we0=%b wmask0=%h addr0=%h required 1 0 0 10", cs0, we0, wmask0, addr0);
        else n_pass++;
        tick();
        n_checks++;
        if (rsp_valid !== '0) $display("FAIL rd_early: got rsp_valid %b required 0", rsp_valid);
        else n_pass++;
        tick();
        n_checks++;
        if (rsp_valid !== 4'b0010 || rsp_rdata !== 32'hDEADBEEF)
            $display("FAIL raw_rsp: got %b %h required 0010 deadbeef", rsp_valid, rsp_rdata);
        else n_pass++;
        drain();
    endtask

    task automatic test_partial_mask();
        logic [NR-1:0] g;
        set_req(0, 1'b1, 4'hF, 8'h20, 32'hFFFFFFFF);
        set_req(3, 1'b1, 4'b0101, 8'h20, 32'h11223344);
        set_req(1, 1'b0, 4'h0, 8'h20, '0);
        req_valid = 4'b0001; arb_step(g); tick();
        req_valid = 4'b1000; arb_step(g); tick();
        n_checks++;
        if (wmask0 !== 4'b0101 || din0 !== 32'h11223344)
            $display("FAIL pm_cmd: wmask0=%b din0=%h required 0101 11223344", wmask0, din0);
        else n_pass++;
        req_valid = 4'b0010; arb_step(g); tick();
        req_valid = '0;
        tick();
        tick();
        n_checks++;
        if (rsp_valid !== 4'b0010 || rsp_rdata !== 32'hFF22FF44)
            $display("FAIL pm_rsp: got %b %h required 0010 ff22ff44", rsp_valid, rsp_rdata);
        else n_pass++;
        drain();
    endtask

    task automatic test_zero_mask();
        logic [NR-1:0] g;
        set_req(3, 1'b1, 4'h0, 8'h30, 32'h12345678);
        req_valid = 4'b1000;
        arb_step(g);
        tick();
        req_valid = '0;
        n_checks++;
        if ({cs0, we0, wmask0} !== {1'b1, 1'b1, 4'h0} || busy !== 1'b0)
            $display("FAIL zero_mask: cs0=%b we0=%b wmask0=%b busy=%b required 1 1 0000 0", cs0, we0, wmask0, busy);
        else n_pass++;
        tick();
        n_checks++;
        if (cs0 !== 1'b0 || addr0 !== 8'h30 || din0 !== 32'h12345678)
            $display("FAIL cmd_hold: cs0=%b addr0=%h din0=%h required 0 30 12345678", cs0, addr0, din0);
        else n_pass++;
    endtask

    task automatic test_enable_wrap();
        logic [NR-1:0] g;
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, 4'hF, AW'(8'h50 + i), '0);
        req_valid = 4'b0100; arb_step(g); tick();
        req_valid = 4'b0001; arb_step(g);
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) $display("FAIL wrap_grant: got %b required 0001", req_ready);
        else n_pass++;
        tick();
        req_valid = '1; arb_step(g);
        #1;
        n_checks++;
        if (req_ready !== 4'b0010) $display("FAIL ptr_after_wrap: got %b required 0010", req_ready);
        else n_pass++;
        tick();
        arb_step(g); tick();
        en = 1'b0;
        arb_step(g);
        #1;
        n_checks++;
        if (req_ready !== '0 || busy !== 1'b1)
            $display("FAIL en_block: ready=%b busy=%b required 0000 1", req_ready, busy);
        else n_pass++;
        tick();
        n_checks++;
        if (cs0 !== 1'b0 || busy !== 1'b1) $display("FAIL en_inflight: cs0=%b busy=%b required 0 1", cs0, busy);
        else n_pass++;
        drain();
        tick();
        n_checks++;
        if (busy !== 1'b0 || req_ready !== '0 || cs0 !== 1'b0)
            $display("FAIL en_idle: busy=%b ready=%b cs0=%b required 0 0000 0", busy, req_ready, cs0);
        else n_pass++;
        req_valid = '0;
        en = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram_mem[i] <= 32'hA5000000 | DW'(i);
            shadow[i]  = 32'hA5000000 | DW'(i);
        end
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, '0, '0, '0);
        test_reset();
        test_round_robin();
        test_write_read();
        test_partial_mask();
        test_zero_mask();
        test_enable_wrap();
        repeat (4) tick();
        n_checks++;
        if (sb.size() != 0) $display("FAIL sb_empty: %0d outstanding, required 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ram_port0_arbiter.md
# ram_port0_arbiter

Round-robin arbiter that shares the read/write port 0 of the `ram_proj` SRAM between `NUM_REQ` independent requesters. It accepts one request per cycle and issues it to the RAM as a registered command. Each read's data is routed back to the requester that issued it through an in-flight tag pipeline. It sits between the requester logic and the `ram_proj` `cs0/we0/wmask0/addr0/din0/dout0` pins; port 1 is untouched.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `ADDR_WIDTH`, 8: RAM address width.
- `DATA_WIDTH`, 32: RAM data width.
- `NUM_WMASK`, 4: write-mask bits, one per `DATA_WIDTH/NUM_WMASK`-bit lane.
- `RD_LATENCY`, 1: cycles from `cs0` issue to valid `dout0`.

Clocking is fixed: one clock; reset is asynchronous and active-low.

- `clk0`  in  1  sole clock; shared with RAM port 0.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  arbitration enable; 0 blocks new grants.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_ready`  out  NUM_REQ  one-hot grant; the request is accepted when valid & ready.
- `req_we`  in  NUM_REQ  1 = write, 0 = read.
- `req_wmask`  in  NUM_REQ*NUM_WMASK  per-requester write mask.
- `req_addr`  in  NUM_REQ*ADDR_WIDTH  per-requester address.
- `req_wdata`  in  NUM_REQ*DATA_WIDTH  per-requester write data.
- `rsp_valid`  out  NUM_REQ  one-hot read-data strobe; no backpressure.
- `rsp_rdata`  out  DATA_WIDTH  read data, shared by all requesters and qualified by `rsp_valid`.
- `busy`  out  1  high while any read is in flight.
- `cs0`  out  1  RAM chip select, active high.
- `we0`  out  1  RAM write enable, active high.
- `wmask0`  out  NUM_WMASK  RAM write mask.
- `addr0`  out  ADDR_WIDTH  RAM address.
- `din0`  out  DATA_WIDTH  RAM write data.
- `dout0`  in  DATA_WIDTH  RAM read data.

## Operation
- **Grant selection:** the grant goes to the first requester with `req_valid` set, searching upward from `ptr` and wrapping NUM_REQ-1 → 0.
  - `req_ready` depends combinationally on `req_valid`, `ptr` and `en`.
  - `req_valid` must not depend on `req_ready`.
- **Pointer update:** on a grant to index i, `ptr` becomes (i+1) mod NUM_REQ. Without a grant, `ptr` holds.
- **Command issue:** an accepted request is registered onto `cs0/we0/wmask0/addr0/din0` for exactly one cycle.
  - With no grant, `cs0` = 0 and the other RAM outputs hold their last value.
  - For reads, `we0` = 0 and `wmask0` is driven to 0.
- **Write with all-zero mask:** still issues `cs0` = 1, `we0` = 1. The RAM no-op is the RAM's concern.
- **Read tagging:** each read pushes {valid, one-hot id} into a RD_LATENCY+1 deep shift register. Writes push an invalid entry.
- **Read return:** at the pipeline tail, `dout0` is registered into `rsp_rdata` and the id drives `rsp_valid`.
- **Write responses:** writes produce no response.
- **`busy`:** the OR of all valid tag-pipeline entries.
- **`en` = 0:** no new grants and `req_ready` = 0. In-flight reads still complete.
- **Reset:**
  - `ptr` = 0, tag pipeline cleared.
  - `cs0`, `we0`, `rsp_valid`, `busy` = 0.
  - `wmask0`, `addr0`, `din0`, `rsp_rdata` = 0.
  - Reads in flight at reset assertion are dropped, with no response.

## Timing
- **Throughput:** one request per cycle; back-to-back grants are allowed to the same or different requesters.
- **Accept to RAM:** request accepted at edge T → `cs0` high in cycle T+1.
- **Read latency:** `rsp_valid`/`rsp_rdata` valid in cycle T+2+RD_LATENCY (T+3 at the default).
- **Response form:** each response is a single-cycle pulse, in acceptance order.
- **Read-after-write:** a write at T followed by a read of the same address at T+1 returns the written data, since the RAM commits writes in command order.

## Structure
- **Package `ram_arb_pkg`:**
  - default parameter constants;
  - `ram_cmd_t` struct {we, wmask, addr, wdata};
  - `rsp_tag_t` struct {valid, id one-hot}.
- **Sub-module `rr_arbiter`:** combinational rotating-priority one-hot grant plus the registered `ptr`. It is reusable for a future port-1 read arbiter.
- **Top:** holds the command register, tag shift register and response register.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-read → all outputs 0 next cycle; after release, no `rsp_valid` for the dropped read.
- **Round-robin fairness:** all 4 `req_valid` held high for 8 cycles → grants 0,1,2,3,0,1,2,3; `cs0` high for 8 consecutive cycles from T+1.
- **Write then read:** requester 2 writes 0xDEADBEEF to addr 0x10 with mask 4'b1111, then requester 1 reads 0x10 → `rsp_valid` = 4'b0010 with `rsp_rdata` = 0xDEADBEEF, exactly 3 cycles after the read is accepted.
- **Partial mask:** write 0x11223344 with mask 4'b0101 over 0xFFFFFFFF, then read → 0xFF22FF44.
- **Enable and wrap:** `ptr` = 3, only requester 0 valid → grant 0, then `ptr` = 1. With `en` = 0 and reads in flight → no grants, responses still return, `busy` falls after the last one.
